// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the DataMemory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ACCESS)
//   M0 / M1     : requester ids (MEM stage / loader-DMA)
//   F3_*        : RV32 load/store width codes; the arbiter only passes
//                 funct3 through, the names exist for requesters and benches.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's req/gnt port onto the DataMemory arbiter.
//   req, we, addr, wdata, funct3 : request fields, held stable until gnt
//   gnt    : one-cycle grant, fields sampled in this cycle
//   rvalid : one-cycle read-data-valid pulse (loads only)
//   rdata  : read data, valid while rvalid, held otherwise
// Modports: master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        funct3;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, funct3,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, funct3,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arb_select.sv
// dmem_arb_select: winner selection for the DataMemory arbiter.
//   clk, rst_n     : clock, synchronous active-low reset
//   req0_i, req1_i : requests from m0 / m1
//   arb_i          : arbitration strobe (arbiter idle and out of reset)
//   win_id_o       : winning requester id (M0/M1)
//   win_valid_o    : a winner exists this cycle (equals the grant strobe)
// Default build: round-robin, pointer holds the last granted id and resets
// to M1 so m0 wins the first tie.
// With DMEM_ARB_M0_PRIORITY_EN defined: m0 has strict priority, and a
// saturating starvation counter forces an m1 grant after STARVE_MAX losses.
module dmem_arb_select
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
  input  logic arb_i,
  output logic win_id_o,
  output logic win_valid_o
);

  assign win_valid_o = arb_i & (req0_i | req1_i);

`ifdef DMEM_ARB_M0_PRIORITY_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    win_id_o = M0;
    if (req1_i && (starve_q == CNT_MAX)) begin
      win_id_o = M1;
    end else if (!req0_i) begin
      win_id_o = M1;
    end

    starve_d = starve_q;
    if (arb_i) begin
      // m1 absent or served: forget its history; m1 lost to m0: count it
      if (!req1_i || (win_id_o == M1)) begin
        starve_d = '0;
      end else if (starve_q != CNT_MAX) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic last_q, last_d;

  always_comb begin
    if (req0_i && req1_i) begin
      win_id_o = (last_q == M1) ? M0 : M1;
    end else begin
      win_id_o = req0_i ? M0 : M1;
    end
    last_d = win_valid_o ? win_id_o : last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= M1;
    end else begin
      last_q <= last_d;
    end
  end

  // STARVE_MAX only matters for the priority build
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DataMemory between the MEM stage (m0)
// and the loader/debug DMA port (m1).
//   clk, rst_n  : system clock, synchronous active-low reset
//   m0, m1      : dmem_arbiter_if.slave requester ports
//   mem_addr    : DataMemory address
//   mem_read    : DataMemory MemRead, high only in ACCESS for loads
//   mem_write   : DataMemory MemWrite, high only in ACCESS for stores
//   mem_wdata   : DataMemory data_in
//   mem_funct3  : DataMemory function3 (passed through, not interpreted)
//   mem_rdata   : DataMemory data_out, combinational read of mem_addr
// Timing: gnt in cycle N (IDLE), memory strobe in N+1 (ACCESS), rvalid in
// N+2 for loads. A new grant may overlap the previous rvalid cycle.
// Optional build macro: DMEM_ARB_M0_PRIORITY_EN (m0 priority with m1
// starvation guard, see dmem_arb_select).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state_q, state_d;

  logic win_id, win_valid, arb;

  logic              id_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        f3_q;

  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [2:0]        f3_d;

  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              load_done;

  // No grants while reset is asserted, even though state already reads IDLE
  assign arb = (state_q == IDLE) & rst_n;

  dmem_arb_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_select (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_i      (m0.req),
    .req1_i      (m1.req),
    .arb_i       (arb),
    .win_id_o    (win_id),
    .win_valid_o (win_valid)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d    = m0.we;
    addr_d  = m0.addr;
    wdata_d = m0.wdata;
    f3_d    = m0.funct3;
    if (win_id == M1) begin
      we_d    = m1.we;
      addr_d  = m1.addr;
      wdata_d = m1.wdata;
      f3_d    = m1.funct3;
    end
  end

  assign m0.gnt = win_valid & (win_id == M0);
  assign m1.gnt = win_valid & (win_id == M1);

  // Strobes decode the current state only, so a store in ACCESS still
  // commits when rst_n is low at the closing edge.
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_funct3 = f3_q;
  assign mem_write  = (state_q == ACCESS) &  we_q;
  assign mem_read   = (state_q == ACCESS) & ~we_q;

  assign load_done = (state_q == ACCESS) & ~we_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= M0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (win_valid) begin
        id_q    <= win_id;
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        f3_q    <= f3_d;
      end
      rvalid0_q <= load_done & (id_q == M0);
      rvalid1_q <= load_done & (id_q == M1);
      if (load_done && (id_q == M0)) rdata0_q <= mem_rdata;
      if (load_done && (id_q == M1)) rdata1_q <= mem_rdata;
    end
  end

  assign m0.rvalid = rvalid0_q;
  assign m0.rdata  = rdata0_q;
  assign m1.rvalid = rvalid1_q;
  assign m1.rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
`ifdef DMEM_ARB_M0_PRIORITY_EN
  localparam int STARVE_MAX = 2;
`else
  localparam int STARVE_MAX = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [2:0]        mem_funct3;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0         (m0_if),
    .m1         (m1_if),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata)
  );

  // DataMemory stand-in: combinational read, write on the rising edge
  logic [DATA_W-1:0] stub_mem [64];
  assign mem_rdata = stub_mem[mem_addr];
  always @(posedge clk) if (mem_write) stub_mem[mem_addr] <= mem_wdata;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  logic [2:0] f3_tab [8] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW};

  function automatic logic [DATA_W-1:0] init_val(int i);
    return 32'hC0DE_0000 + DATA_W'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Schedule-based: a grant in cycle c books the memory for cycle c+1 and,
  // for loads, a response in cycle c+2.
  logic [DATA_W-1:0] model_mem [64];
  bit                acc_now = 0, acc_we = 0, rsp_now = 0;
  int                acc_who = 0, rsp_who = 0;
  logic [DATA_W-1:0] rd_m [2] = '{'0, '0};
  logic [ADDR_W-1:0] hold_addr = '0;
  logic [DATA_W-1:0] hold_wdata = '0;
  logic [2:0]        hold_f3 = '0;
  int                last_m = 1;
`ifdef DMEM_ARB_M0_PRIORITY_EN
  int                starve_m = 0;
`endif

  function automatic int pick(bit a, bit b);
`ifdef DMEM_ARB_M0_PRIORITY_EN
    if (b && starve_m == STARVE_MAX) return 1;
    return a ? 0 : 1;
`else
    if (a && b) return (last_m == 1) ? 0 : 1;
    return a ? 0 : 1;
`endif
  endfunction

  always @(negedge clk) begin
    bit r0, r1, gv, idle_c;
    int w;
    if (chk_en) begin
      r0 = m0_if.req;
      r1 = m1_if.req;
      idle_c = rst_n && !acc_now;
      gv = idle_c && (r0 || r1);
      w = pick(r0, r1);
      chk("m0_gnt",     64'(m0_if.gnt),     64'(gv && w == 0));
      chk("m1_gnt",     64'(m1_if.gnt),     64'(gv && w == 1));
      chk("mem_read",   64'(mem_read),      64'(acc_now && !acc_we));
      chk("mem_write",  64'(mem_write),     64'(acc_now && acc_we));
      chk("mem_addr",   64'(mem_addr),      64'(hold_addr));
      chk("mem_wdata",  64'(mem_wdata),     64'(hold_wdata));
      chk("mem_funct3", 64'(mem_funct3),    64'(hold_f3));
      chk("m0_rvalid",  64'(m0_if.rvalid),  64'(rsp_now && rsp_who == 0));
      chk("m1_rvalid",  64'(m1_if.rvalid),  64'(rsp_now && rsp_who == 1));
      chk("m0_rdata",   64'(m0_if.rdata),   64'(rd_m[0]));
      chk("m1_rdata",   64'(m1_if.rdata),   64'(rd_m[1]));

      // advance to the next cycle
      if (acc_now && acc_we) model_mem[hold_addr] = hold_wdata;
      if (!rst_n) begin
        acc_now = 0; rsp_now = 0; rd_m = '{'0, '0};
        hold_addr = '0; hold_wdata = '0; hold_f3 = '0; last_m = 1;
`ifdef DMEM_ARB_M0_PRIORITY_EN
        starve_m = 0;
`endif
      end else begin
        rsp_now = acc_now && !acc_we;
        rsp_who = acc_who;
        if (rsp_now) rd_m[acc_who] = model_mem[hold_addr];
`ifdef DMEM_ARB_M0_PRIORITY_EN
        if (gv) begin
          if (w == 1) starve_m = 0;
          else if (r1 && starve_m < STARVE_MAX) starve_m = starve_m + 1;
        end
        if (idle_c && !r1) starve_m = 0;
`endif
        if (gv) begin
          acc_now = 1;
          acc_who = w;
          acc_we = (w == 1) ? m1_if.we : m0_if.we;
          hold_addr  = (w == 1) ? m1_if.addr   : m0_if.addr;
          hold_wdata = (w == 1) ? m1_if.wdata  : m0_if.wdata;
          hold_f3    = (w == 1) ? m1_if.funct3 : m0_if.funct3;
          last_m = w;
        end else begin
          acc_now = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int who, input bit we, input int addr,
                         input logic [DATA_W-1:0] d, input logic [2:0] f3);
    if (who == 0) begin
      m0_if.req = 1'b1; m0_if.we = we; m0_if.addr = ADDR_W'(addr);
      m0_if.wdata = d; m0_if.funct3 = f3;
    end else begin
      m1_if.req = 1'b1; m1_if.we = we; m1_if.addr = ADDR_W'(addr);
      m1_if.wdata = d; m1_if.funct3 = f3;
    end
  endtask

  task automatic clr_req(input int who);
    if (who == 0) m0_if.req = 1'b0;
    else m1_if.req = 1'b0;
  endtask

  task automatic wait_gnt(input int who);
    bit ok;
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if ((who == 0 && m0_if.gnt) || (who == 1 && m1_if.gnt)) ok = 1;
      else tick;
    end
    if (!ok) chk("gnt_timeout", 64'(ok), 64'(1));
  endtask

  // request, wait for the grant, release; returns inside the ACCESS cycle
  task automatic do_access(input int who, input bit we, input int addr,
                           input logic [DATA_W-1:0] d, input logic [2:0] f3);
    set_req(who, we, addr, d, f3);
    wait_gnt(who);
    tick;
    clr_req(who);
  endtask

  task automatic drive_rand(input int who, input bit granted);
    bit cur;
    cur = (who == 0) ? m0_if.req : m1_if.req;
    if (!cur || granted) begin
      if ($urandom_range(0, 1) == 1)
        set_req(who, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                DATA_W'($urandom), f3_tab[$urandom_range(0, 7)]);
      else
        clr_req(who);
    end else if ($urandom_range(0, 15) == 0) begin
      clr_req(who);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int gseq[$];
    int rseq[$];
    logic [DATA_W-1:0] rdat[$];
    int exp_g [6];
    bit g0, g1;

    for (int i = 0; i < 64; i++) begin
      stub_mem[i] = init_val(i);
      model_mem[i] = init_val(i);
    end
    m0_if.req = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.funct3 = '0;
    m1_if.req = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.funct3 = '0;

    // 1: reset with both requesting
    rst_n = 0;
    set_req(0, 0, 5, '0, F3_LW);
    set_req(1, 0, 6, '0, F3_LW);
    tick;
    chk_en = 1;
    @(negedge clk);
    chk("rst_gnt", 64'({m1_if.gnt, m0_if.gnt}), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    tick;
    rst_n = 1;
    @(negedge clk);
    chk("first_gnt_m0", 64'({m1_if.gnt, m0_if.gnt}), 64'(2'b01));
    tick;
    clr_req(0); clr_req(1);
    repeat (3) tick;

    // 2: m0 store
    do_access(0, 1, 2, 32'hA5A5_A5A5, F3_SW);
    @(negedge clk);
    chk("t2_mem_write", 64'(mem_write), 64'(1));
    chk("t2_mem_addr", 64'(mem_addr), 64'(2));
    chk("t2_mem_wdata", 64'(mem_wdata), 64'(32'hA5A5_A5A5));
    tick;
    @(negedge clk);
    chk("t2_no_rvalid", 64'(m0_if.rvalid), 64'(0));
    tick;

    // 3: m0 load back
    do_access(0, 0, 2, '0, F3_LW);
    @(negedge clk);
    chk("t3_mem_read", 64'(mem_read), 64'(1));
    tick;
    @(negedge clk);
    chk("t3_m0_rvalid", 64'(m0_if.rvalid), 64'(1));
    chk("t3_m0_rdata", 64'(m0_if.rdata), 64'(32'hA5A5_A5A5));
    chk("t3_m1_rvalid", 64'(m1_if.rvalid), 64'(0));
    tick;

    // leave m1 as last winner so the next tie goes to m0
    do_access(1, 0, 1, '0, F3_LW);
    tick; tick;

    // 4/5: both requesting continuously
    set_req(0, 0, 0, '0, F3_LW);
    set_req(1, 0, 1, '0, F3_LW);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (m0_if.gnt) gseq.push_back(0);
      if (m1_if.gnt) gseq.push_back(1);
      if (m0_if.rvalid) begin rseq.push_back(0); rdat.push_back(m0_if.rdata); end
      if (m1_if.rvalid) begin rseq.push_back(1); rdat.push_back(m1_if.rdata); end
      tick;
    end
    clr_req(0); clr_req(1);
`ifdef DMEM_ARB_M0_PRIORITY_EN
    exp_g = '{0, 0, 1, 0, 0, 1};
`else
    exp_g = '{0, 1, 0, 1, 0, 1};
`endif
    chk("t4_ngrants", 64'(gseq.size()), 64'(7));
    chk("t4_nrvalid", 64'(rseq.size()), 64'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < gseq.size()) chk($sformatf("t4_grant%0d", i), 64'(gseq[i]), 64'(exp_g[i]));
      if (i < rseq.size()) begin
        chk($sformatf("t4_rvalid%0d", i), 64'(rseq[i]), 64'(exp_g[i]));
        chk($sformatf("t4_rdata%0d", i), 64'(rdat[i]), 64'(init_val(exp_g[i])));
      end
    end
    repeat (3) tick;

    // 6a: reset during ACCESS of an m1 load
    do_access(1, 0, 3, '0, F3_LW);
    rst_n = 0;
    @(negedge clk);
    chk("t6_mem_read", 64'(mem_read), 64'(1));
    tick;
    rst_n = 1;
    @(negedge clk);
    chk("t6_no_rvalid", 64'(m1_if.rvalid), 64'(0));
    chk("t6_idle", 64'({mem_read, mem_write}), 64'(0));
    tick;

    // 6b: reset during ACCESS of an m1 store still commits
    do_access(1, 1, 3, 32'h0000_00FF, F3_SW);
    rst_n = 0;
    tick;
    rst_n = 1;
    tick;
    do_access(0, 0, 3, '0, F3_LW);
    tick;
    @(negedge clk);
    chk("t6_rvalid", 64'(m0_if.rvalid), 64'(1));
    chk("t6_rdata", 64'(m0_if.rdata), 64'(32'h0000_00FF));
    tick;

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g0 = m0_if.gnt;
      g1 = m1_if.gnt;
      tick;
      rst_n = ($urandom_range(0, 199) != 0);
      drive_rand(0, g0);
      drive_rand(1, g1);
    end
    clr_req(0); clr_req(1);
    rst_n = 1;
    repeat (4) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
